spi_master: RTL and testbench
=============================

# spi_master

SPI initiator that drives `cs`, `sclk` and `mosi` and captures `miso`. It runs single 16-bit frames against the team's SPI peripheral FSM and memory. A host issues one transaction at a time: a 7-bit address, a read/write flag and, for writes, one data byte. For reads, the byte returned on `miso` is presented on `rdata`. It sits between on-chip test/control logic and the SPI pins.

## Interface
Parameters:
- `HALF`, 8: `sclk` half-period in `clk` cycles; legal minimum 4.
- `GAP`, 4: `clk` cycles `cs` stays high after a frame before `done`; legal minimum 2.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `start`  in  1  request; sampled only while idle.
- `rw`  in  1  1 = read, 0 = write; sampled with `start`.
- `addr`  in  7  target address; sampled with `start`.
- `wdata`  in  8  write byte; sampled with `start`.
- `busy`  out  1  high from the cycle after acceptance through the cycle before `done`.
- `done`  out  1  one-cycle pulse at end of transaction.
- `rdata`  out  8  last read byte.
- `cs`  out  1  chip select, active low.
- `sclk`  out  1  serial clock, idle low.
- `mosi`  out  1  serial data out.
- `miso`  in  1  serial data in; treated as asynchronous, sampled directly at `sclk` rise.

## Operation
- Frame is 16 bits, MSB first: byte 0 = {addr[6:0], rw}; byte 1 = wdata (write) or 8'h00 driven on `mosi` (read).
- `mosi` changes only while `sclk` is low. `miso` is sampled on the `clk` edge where registered `sclk` goes 0→1.
- Only bits 8..15 are shifted into the receive register.
- States:
  - IDLE: waits for `start`.
  - SETUP: `cs` low, `sclk` low for HALF cycles.
  - HIGH: `sclk` high for HALF cycles.
  - LOW: `sclk` low for HALF cycles; advances the bit counter.
  - GAP: `cs` high for GAP cycles.
  - Then back to IDLE.
- Transitions: IDLE→SETUP on `start`; SETUP→HIGH; HIGH→LOW; LOW→HIGH while bit count < 16. After the 16th LOW: →GAP. Then GAP→IDLE, with `done` asserted.
- The final LOW phase is the trailing hold, so the peripheral sees its 16th rising edge with `cs` still low for ≥HALF cycles.
- Read: `rdata` loads the received byte in the `done` cycle and holds until the next read's `done`. Write: `rdata` is unchanged.
- `start` while busy is ignored (not queued). `start` in the `done` cycle is accepted.
- Reset values: `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rdata`=8'h00, state IDLE.
- Reset mid-frame aborts: `cs`=1, `sclk`=0 on the next cycle; no `done`; `rdata` cleared.
- `mosi`=0 whenever `cs`=1.

## Timing
- Acceptance cycle T (IDLE, `start`=1).
- T+1: `cs`=0, `busy`=1, `sclk`=0, `mosi`=addr[6].
- `sclk` rises at T+1+HALF+2k·HALF, for k = 0..15.
- `cs` returns high at T+1+33·HALF.
- `done`=1 and `busy`=0 at T+1+33·HALF+GAP.
- Frame-to-frame minimum: `cs` high for GAP cycles. This also satisfies the peripheral's return-to-idle on `cs` high.
- Read turnaround: the peripheral needs several `clk` cycles after its 8th rising edge to load its shift register. HALF ≥ 4 guarantees `miso` is valid by the 9th rise.

## Structure
- Package `spi_pkg`:
  - state enum (IDLE, SETUP, HIGH, LOW, GAP);
  - constants ADDR_W=7, DATA_W=8, FRAME_BITS=16, RW_READ=1'b1.
- Sub-module `spi_half_timer`: loadable down-counter that emits a one-cycle tick after HALF cycles (reused for GAP).
- Top holds the FSM, the 16-bit transmit shift register, the 8-bit receive shift register and the 5-bit bit counter.

## Test plan
All scenarios use HALF=4, GAP=2.
- Reset held 3 cycles mid-idle → `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rdata`=8'h00.
- Write, addr=7'h15, wdata=8'hA5:
  - `mosi` at the 16 `sclk` rises = 0010101_0_10100101;
  - `cs` low exactly 132 cycles;
  - `done` at T+135;
  - `rdata` unchanged.
- Read, addr=7'h7F, bench slave model returns 8'h3C:
  - `mosi` = 11111111 then eight 0s;
  - `rdata`=8'h3C in the `done` cycle.
- `start` pulsed at T+10 during a frame → ignored, single `done`. `start` in the `done` cycle → `cs` low on the next cycle.
- `reset` asserted just after the 5th `sclk` rise → `cs`=1 next cycle, no `done`; the next `start` produces a full 16-bit frame.
- Loopback with the peripheral FSM and memory (HALF=8): write 8'h5A to addr 7'h03, then read addr 7'h03 → `rdata`=8'h5A.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the single-frame SPI initiator.
package spi_pkg;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FRAME_BITS = 16;
  localparam logic        RW_READ    = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StGap
  } spi_state_e;

  // Reads shift out zeros in the data byte.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [ADDR_W-1:0] addr,
                                                         input logic              rw,
                                                         input logic [DATA_W-1:0] wdata);
    return {addr, rw, (rw == RW_READ) ? {DATA_W{1'b0}} : wdata};
  endfunction

endpackage

// File: rtl/spi_half_timer.sv
// Loadable down-counter: after a load of len_i, tick_o pulses in the len_i-th cycle.
module spi_half_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] len_i,
  output logic             tick_o
);

  logic [Width-1:0] cnt_q;
  logic             active_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load_i) begin
      cnt_q    <= len_i - Width'(1);
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - Width'(1);
      end
    end
  end

  assign tick_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// SPI initiator running one 16-bit {addr, rw, data} frame per host request.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned HALF = 8,
  parameter int unsigned GAP  = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              rw_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              cs_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i
);

  localparam int unsigned     TimerMax = (HALF > GAP) ? HALF : GAP;
  localparam int unsigned     TimerW   = $clog2(TimerMax + 1);
  localparam int unsigned     CntW     = $clog2(FRAME_BITS + 1);
  localparam logic [CntW-1:0] LastBit  = CntW'(FRAME_BITS);
  localparam logic [CntW-1:0] RxFirst  = CntW'(FRAME_BITS - DATA_W);
  localparam logic [TimerW-1:0] HalfLen = TimerW'(HALF);
  localparam logic [TimerW-1:0] GapLen  = TimerW'(GAP);

  spi_state_e              state_q;
  logic [FRAME_BITS-1:0]   tx_q;
  logic [DATA_W-1:0]       rx_q;
  logic [CntW-1:0]         bit_cnt_q;
  logic                    rw_q;
  logic                    busy_q;
  logic                    done_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    cs_q;
  logic                    sclk_q;

  logic                    accept;
  logic                    last_bit;
  logic                    timer_load;
  logic                    timer_tick;
  logic [TimerW-1:0]       timer_len;

  // Every phase change reloads the timer; GAP ends the chain and lets it expire.
  always_comb begin
    accept     = (state_q == StIdle) && start_i;
    last_bit   = (bit_cnt_q == LastBit);
    timer_load = accept || (timer_tick && (state_q != StGap));
    timer_len  = ((state_q == StLow) && last_bit) ? GapLen : HalfLen;
  end

  spi_half_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .load_i (timer_load),
    .len_i  (timer_len),
    .tick_o (timer_tick)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q   <= StSetup;
            tx_q      <= build_frame(addr_i, rw_i, wdata_i);
            rx_q      <= '0;
            bit_cnt_q <= '0;
            rw_q      <= rw_i;
            busy_q    <= 1'b1;
            cs_q      <= 1'b0;
          end
        end
        StSetup: begin
          if (timer_tick) begin
            state_q <= StHigh;
            sclk_q  <= 1'b1;
          end
        end
        StHigh: begin
          // Next bit is presented on the falling edge; zeros fill in behind.
          if (timer_tick) begin
            state_q   <= StLow;
            sclk_q    <= 1'b0;
            tx_q      <= {tx_q[FRAME_BITS-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
        end
        StLow: begin
          if (timer_tick) begin
            if (last_bit) begin
              state_q <= StGap;
              cs_q    <= 1'b1;
            end else begin
              state_q <= StHigh;
              sclk_q  <= 1'b1;
              // miso sampled on the same edge the registered sclk rises.
              if (bit_cnt_q >= RxFirst) begin
                rx_q <= {rx_q[DATA_W-2:0], miso_i};
              end
            end
          end
        end
        StGap: begin
          if (timer_tick) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (rw_q == RW_READ) begin
              rdata_q <= rx_q;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign cs_o    = cs_q;
  assign sclk_o  = sclk_q;
  assign mosi_o  = tx_q[FRAME_BITS-1];

endmodule

// File: tb/tb_spi_master.sv
// Randomised bench for spi_master with a cycle-indexed frame model and SPI memory slaves.
module tb_spi_master;

  localparam int H     = 4;
  localparam int G     = 2;
  localparam int CsLow = 33 * H;
  localparam int Dn    = 33 * H + G + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, rw, busy, done, cs, sclk, mosi;
  logic       miso = 1'b0;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;

  logic       reset8, start8, rw8, busy8, done8, cs8, sclk8, mosi8;
  logic       miso8 = 1'b0;
  logic [6:0] addr8;
  logic [7:0] wdata8, rdata8;

  spi_master #(.HALF(H), .GAP(G)) u_dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .rw_i(rw), .addr_i(addr),
    .wdata_i(wdata), .busy_o(busy), .done_o(done), .rdata_o(rdata), .cs_o(cs),
    .sclk_o(sclk), .mosi_o(mosi), .miso_i(miso)
  );

  spi_master #(.HALF(8), .GAP(4)) u_dut8 (
    .clk_i(clk), .reset_i(reset8), .start_i(start8), .rw_i(rw8), .addr_i(addr8),
    .wdata_i(wdata8), .busy_o(busy8), .done_o(done8), .rdata_o(rdata8), .cs_o(cs8),
    .sclk_o(sclk8), .mosi_o(mosi8), .miso_i(miso8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Peripheral memory models: 8 rises of {addr, rw}, then data in or out, MSB first.
  logic [7:0]  mem0[128];
  int          s0_cnt = 0;
  logic [15:0] s0_sr;
  logic        s0_rd;
  logic [6:0]  s0_addr;
  logic [7:0]  s0_out;

  always @(negedge cs) s0_cnt = 0;
  always @(posedge cs) miso = 1'b0;
  always @(posedge sclk) if (cs === 1'b0) begin
    s0_sr = {s0_sr[14:0], mosi};
    s0_cnt++;
    if (s0_cnt == 8) begin
      s0_rd   = s0_sr[0];
      s0_addr = s0_sr[7:1];
      s0_out  = mem0[s0_sr[7:1]];
    end
    if (s0_rd && s0_cnt >= 8 && s0_cnt < 16) begin
      miso   = s0_out[7];
      s0_out = {s0_out[6:0], 1'b0};
    end
    if (!s0_rd && s0_cnt == 16) mem0[s0_addr] = s0_sr[7:0];
  end

  logic [7:0]  mem8[128];
  int          s8_cnt = 0;
  logic [15:0] s8_sr;
  logic        s8_rd;
  logic [6:0]  s8_addr;
  logic [7:0]  s8_out;

  always @(negedge cs8) s8_cnt = 0;
  always @(posedge cs8) miso8 = 1'b0;
  always @(posedge sclk8) if (cs8 === 1'b0) begin
    s8_sr = {s8_sr[14:0], mosi8};
    s8_cnt++;
    if (s8_cnt == 8) begin
      s8_rd   = s8_sr[0];
      s8_addr = s8_sr[7:1];
      s8_out  = mem8[s8_sr[7:1]];
    end
    if (s8_rd && s8_cnt >= 8 && s8_cnt < 16) begin
      miso8  = s8_out[7];
      s8_out = {s8_out[6:0], 1'b0};
    end
    if (!s8_rd && s8_cnt == 16) mem8[s8_addr] = s8_sr[7:0];
  end

  // Reference model: m_t is the cycle index since acceptance (0 = idle).
  int          m_t = 0;
  bit          m_valid = 1'b0;
  logic        m_rw;
  logic [6:0]  m_addr;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rdata;
  logic [15:0] m_frame;
  logic [7:0]  exp_mem[128];

  always @(posedge clk) begin
    if (reset) begin
      m_t     = 0;
      m_rdata = 8'h00;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_t == 0 || m_t == Dn) begin
        if (start) begin
          m_t     = 1;
          m_rw    = rw;
          m_addr  = addr;
          m_wdata = wdata;
          m_frame = {addr, rw, rw ? 8'h00 : wdata};
        end else begin
          m_t = 0;
        end
      end else begin
        m_t++;
        if (m_t == Dn) begin
          if (m_rw) m_rdata = exp_mem[m_addr];
          else exp_mem[m_addr] = m_wdata;
        end
      end
    end
  end

  int   c_u, c_b;
  logic e_act, e_sclk, e_mosi, e_busy, e_done;

  always @(negedge clk) if (m_valid) begin
    e_act  = (m_t >= 1) && (m_t <= CsLow);
    c_u    = m_t - 1 - H;
    e_sclk = e_act && (c_u >= 0) && (c_u < 32 * H) && (((c_u / H) % 2) == 0);
    c_b    = (m_t - 1) / (2 * H);
    e_mosi = (e_act && c_b < 16) ? m_frame[15 - c_b] : 1'b0;
    e_busy = (m_t >= 1) && (m_t <= CsLow + G);
    e_done = (m_t == Dn);
    chk("cs",    32'(cs),    32'(!e_act));
    chk("sclk",  32'(sclk),  32'(e_sclk));
    chk("mosi",  32'(mosi),  32'(e_mosi));
    chk("busy",  32'(busy),  32'(e_busy));
    chk("done",  32'(done),  32'(e_done));
    chk("rdata", 32'(rdata), 32'(m_rdata));
  end

  // Called at a negedge with the DUT able to accept; returns at the done negedge.
  task automatic run_txn(input logic r, input logic [6:0] a, input logic [7:0] d,
                         output logic [15:0] cap, output int n_rise, output int cs_low,
                         output int lat, output logic [7:0] rd);
    logic prev;
    bit   seen;
    start = 1'b1; rw = r; addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0;
    cap = '0; n_rise = 0; cs_low = 0; lat = 1; prev = 1'b0; seen = 1'b0; rd = '0;
    for (int i = 0; i < 1000; i++) begin
      if (cs === 1'b0) cs_low++;
      if (sclk && !prev) begin
        cap = {cap[14:0], mosi};
        n_rise++;
      end
      prev = sclk;
      if (done === 1'b1) begin
        seen = 1'b1;
        rd   = rdata;
        break;
      end
      @(negedge clk);
      lat++;
    end
    chk("txn_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_done8(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done8 === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] cap;
    logic [7:0]  rd, d;
    logic [6:0]  a;
    logic        r, prev;
    int          nr, csl, lat, ndone;

    for (int i = 0; i < 128; i++) begin
      mem0[i] = pat(i); exp_mem[i] = pat(i); mem8[i] = pat(i);
    end
    mem0[7'h7F] = 8'h3C; exp_mem[7'h7F] = 8'h3C;

    reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    reset8 = 1'b1; start8 = 1'b0; rw8 = 1'b0; addr8 = '0; wdata8 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0; reset8 = 1'b0;

    run_txn(1'b0, 7'h15, 8'hA5, cap, nr, csl, lat, rd);
    chk("wr_mosi_bits", 32'(cap), 32'h2AA5);
    chk("wr_rises", 32'(nr), 32'd16);
    chk("wr_cs_low_cycles", 32'(csl), 32'd132);
    chk("wr_done_latency", 32'(lat), 32'd135);
    chk("wr_rdata_unchanged", 32'(rd), 32'h00);

    repeat (2) @(negedge clk);
    run_txn(1'b1, 7'h7F, 8'hEE, cap, nr, csl, lat, rd);
    chk("rd_mosi_bits", 32'(cap), 32'hFF00);
    chk("rd_rdata", 32'(rd), 32'h3C);

    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'h00);
    reset = 1'b0;

    // start at T+10 must be dropped
    @(negedge clk);
    start = 1'b1; rw = 1'b0; addr = 7'h05; wdata = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; rw = 1'b1; addr = 7'h06;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("ignored_start_dones", 32'(ndone), 32'd1);

    // start in the done cycle
    start = 1'b1; rw = 1'b0; addr = 7'h02; wdata = 8'h33;
    @(negedge clk);
    start = 1'b0;
    wait_done("first_done");
    start = 1'b1; rw = 1'b1; addr = 7'h02;
    @(negedge clk);
    start = 1'b0;
    chk("done_cycle_accept_cs", 32'(cs), 32'd0);
    wait_done("second_done");
    chk("readback_rdata", 32'(rdata), 32'h33);

    // reset just after the 5th sclk rise
    @(negedge clk);
    start = 1'b1; rw = 1'b0; addr = 7'h2A; wdata = 8'h5C;
    @(negedge clk);
    start = 1'b0;
    prev = 1'b0; nr = 0;
    for (int i = 0; i < 200; i++) begin
      if (sclk && !prev) nr++;
      prev = sclk;
      if (nr == 5) break;
      @(negedge clk);
    end
    chk("abort_reached_5th_rise", 32'(nr), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_cs", 32'(cs), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_rdata", 32'(rdata), 32'h00);
    ndone = 0;
    for (int i = 0; i < 150; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_txn(1'b0, 7'h2A, 8'h5C, cap, nr, csl, lat, rd);
    chk("post_abort_mosi", 32'(cap), 32'h545C);
    chk("post_abort_rises", 32'(nr), 32'd16);
    chk("post_abort_latency", 32'(lat), 32'd135);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      r = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
      d = 8'($urandom);
      run_txn(r, a, d, cap, nr, csl, lat, rd);
      chk("rnd_mosi_bits", 32'(cap), 32'({a, r, r ? 8'h00 : d}));
      chk("rnd_done_latency", 32'(lat), 32'd135);
    end

    // loopback at HALF=8
    @(negedge clk);
    start8 = 1'b1; rw8 = 1'b0; addr8 = 7'h03; wdata8 = 8'h5A;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8("lb_write_done");
    chk("lb_write_rdata", 32'(rdata8), 32'h00);
    @(negedge clk);
    start8 = 1'b1; rw8 = 1'b1; addr8 = 7'h03;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8("lb_read_done");
    chk("lb_read_rdata", 32'(rdata8), 32'h5A);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
